// File: rtl/uart_display_controller.sv
// UART register/display controller: hex rx chars shift into a digit bank; see_bauds shows and transmits the baud rate.
// Optional build macro UART_ECHO_EN: echo accepted rx characters back through the transmitter.
module uart_display_controller #(
  parameter int NUM_DIGITS  = 6,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    see_bauds,
  input  logic [1:0]              baudrate_sel,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    baud_mode
);

  localparam int DW     = 4 * NUM_DIGITS;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [2:0] T_IDLE = 3'd0;
`ifdef UART_ECHO_EN
  localparam logic [2:0] T_ECHO = 3'd1;
`endif
  localparam logic [2:0] T_BAUD = 3'd2;
  localparam logic [2:0] T_CR   = 3'd3;
  localparam logic [2:0] T_LF   = 3'd4;

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic logic [3:0] hex_nibble(input logic [7:0] b);
    return (b <= 8'h39) ? b[3:0] : (b[3:0] + 4'd9);
  endfunction

  function automatic logic [23:0] baud_bcd(input logic [1:0] sel);
    case (sel)
      2'b00:   return 24'h009600;
      2'b01:   return 24'h019200;
      2'b10:   return 24'h057600;
      default: return 24'h115200;
    endcase
  endfunction

  // Index (0 = most significant) of the first digit sent; every baud value has at least four digits.
  function automatic logic [2:0] first_digit(input logic [23:0] bcd);
    if (bcd[23:20] != 4'd0) return 3'd0;
    if (bcd[19:16] != 4'd0) return 3'd1;
    return 3'd2;
  endfunction

  function automatic logic [7:0] digit_ascii(input logic [23:0] bcd, input logic [2:0] idx);
    return 8'h30 + {4'h0, bcd[4*(5-int'(idx)) +: 4]};
  endfunction

  logic [DW-1:0]     live_q, live_d;
  logic              sync1_q, sync2_q, sync3_q, edge_q;
  logic              baud_mode_q, baud_mode_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic [23:0]       tx_bcd_q, tx_bcd_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        state_q, state_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;

  logic        rx_hex, rx_accept, xfer;
  logic [23:0] bcd_now;
  logic [2:0]  first_now;

  assign rx_hex    = rx_valid && is_hex(rx_data);
  assign rx_accept = rx_hex || (rx_valid && rx_data == 8'h0D);
  assign xfer      = tx_valid_q && tx_ready;
  assign bcd_now   = baud_bcd(baudrate_sel);
  assign first_now = first_digit(bcd_now);

  // Digit capture, hold timer and baud display
  always_comb begin
    live_d      = live_q;
    baud_mode_d = baud_mode_q;
    hold_d      = hold_q;
    disp_d      = disp_q;
    if (rx_hex) begin
      live_d = (live_q << 4) | DW'(hex_nibble(rx_data));
    end else if (rx_valid && rx_data == 8'h0D) begin
      live_d = '0;
    end
    if (edge_q) begin
      baud_mode_d = 1'b1;
      hold_d      = HOLD_LOAD;
      disp_d      = DW'({8'h00, bcd_now});
    end else if (baud_mode_q) begin
      if (hold_q == '0) baud_mode_d = 1'b0;
      else              hold_d      = hold_q - 1'b1;
    end
  end

  // Transmit sequencer; outputs are registered so tx_data stays put during stalls
  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    idx_d      = idx_q;
    tx_bcd_d   = tx_bcd_q;
    case (state_q)
      T_IDLE: begin
        if (edge_q) begin
          tx_bcd_d   = bcd_now;
          idx_d      = first_now;
          tx_data_d  = digit_ascii(bcd_now, first_now);
          tx_valid_d = 1'b1;
          state_d    = T_BAUD;
        end
`ifdef UART_ECHO_EN
        else if (rx_accept) begin
          tx_data_d  = rx_data;
          tx_valid_d = 1'b1;
          state_d    = T_ECHO;
        end
`endif
      end
`ifdef UART_ECHO_EN
      T_ECHO: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          state_d    = T_IDLE;
        end
      end
`endif
      T_BAUD: begin
        if (xfer) begin
          if (idx_q == 3'd5) begin
            tx_data_d = 8'h0D;
            state_d   = T_CR;
          end else begin
            idx_d     = idx_q + 3'd1;
            tx_data_d = digit_ascii(tx_bcd_q, idx_q + 3'd1);
          end
        end
      end
      T_CR: begin
        if (xfer) begin
          tx_data_d = 8'h0A;
          state_d   = T_LF;
        end
      end
      T_LF: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          state_d    = T_IDLE;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = T_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      live_q      <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      edge_q      <= 1'b0;
      baud_mode_q <= 1'b0;
      hold_q      <= '0;
      disp_q      <= '0;
      tx_bcd_q    <= '0;
      idx_q       <= '0;
      state_q     <= T_IDLE;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      live_q      <= live_d;
      sync1_q     <= see_bauds;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      edge_q      <= sync2_q & ~sync3_q;
      baud_mode_q <= baud_mode_d;
      hold_q      <= hold_d;
      disp_q      <= disp_d;
      tx_bcd_q    <= tx_bcd_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign digits    = baud_mode_q ? disp_q : live_q;
  assign baud_mode = baud_mode_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_display_controller.sv
// Bench for uart_display_controller: rx digit table, baud display/transmit sequences, stalls and reset abort.
module tb_uart_display_controller;

  localparam int ND = 6;
  localparam int HC = 10;

  logic            clock = 1'b0;
  logic            reset;
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            see_bauds;
  logic [1:0]      baudrate_sel;
  logic            tx_ready;
  logic [7:0]      tx_data;
  logic            tx_valid;
  logic [4*ND-1:0] digits;
  logic            baud_mode;

  uart_display_controller #(.NUM_DIGITS(ND), .HOLD_CYCLES(HC)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .see_bauds(see_bauds), .baudrate_sel(baudrate_sel), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .digits(digits), .baud_mode(baud_mode)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         failures = 0;
  int         n_pop = 0;
  logic [7:0] exp_q[$];
  bit         toggle_en = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  typedef struct {
    logic [7:0]  rx;
    logic [23:0] dig;
    bit          acc;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clock); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic press(input logic [1:0] sel);
    @(posedge clock); #1;
    baudrate_sel = sel;
    see_bauds    = 1'b1;
  endtask

  task automatic wait_drain(input int maxc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clock); #1;
      if (exp_q.size() == 0 && !tx_valid) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL tx_drain_timeout got=%0d_left expected=0_left", exp_q.size());
    end
  endtask

  // tx_ready: held high, or toggled every cycle during the stall test
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      tx_ready = toggle_en ? ~tx_ready : 1'b1;
    end
  end

  // Scoreboard sink: every transfer pops one expected byte; stalled data must hold
  always @(negedge clock) begin
    if (!reset && tx_valid && tx_ready) begin
      n_pop++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected got=%h expected=none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          failures++;
          $display("FAIL tx_byte got=%h expected=%h", tx_data, e);
        end
      end
    end
    if (!reset && stall_prev) begin
      checks++;
      if (!tx_valid || tx_data !== prev_data) begin
        failures++;
        $display("FAIL tx_stall_hold got=%b/%h expected=1/%h", tx_valid, tx_data, prev_data);
      end
    end
    stall_prev = !reset && tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  initial begin
    int base;
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; see_bauds = 1'b0; baudrate_sel = 2'b00;

    tbl[0]  = '{8'h31, 24'h000001, 1'b1};
    tbl[1]  = '{8'h61, 24'h00001A, 1'b1};
    tbl[2]  = '{8'h46, 24'h0001AF, 1'b1};
    tbl[3]  = '{8'h31, 24'h001AF1, 1'b1};
    tbl[4]  = '{8'h32, 24'h01AF12, 1'b1};
    tbl[5]  = '{8'h33, 24'h1AF123, 1'b1};
    tbl[6]  = '{8'h34, 24'hAF1234, 1'b1};
    tbl[7]  = '{8'h35, 24'hF12345, 1'b1};
    tbl[8]  = '{8'h36, 24'h123456, 1'b1};
    tbl[9]  = '{8'h37, 24'h234567, 1'b1};
    tbl[10] = '{8'h0D, 24'h000000, 1'b1};
    tbl[11] = '{8'h47, 24'h000000, 1'b0};
    tbl[12] = '{8'h7A, 24'h000000, 1'b0};
    tbl[13] = '{8'h39, 24'h000009, 1'b1};
    tbl[14] = '{8'h3A, 24'h000009, 1'b0};
    tbl[15] = '{8'h66, 24'h00009F, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_baud_mode", 32'(baud_mode), 32'h0);
    chk("reset_tx_valid", 32'(tx_valid), 32'h0);
    chk("reset_tx_data", 32'(tx_data), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
`ifdef UART_ECHO_EN
      if (tbl[i].acc) exp_q.push_back(tbl[i].rx);
`endif
      send_rx(tbl[i].rx);
      chk($sformatf("rx_vec%0d", i), 32'(digits), 32'(tbl[i].dig));
      repeat (2) @(posedge clock);
    end
    wait_drain(20);

    // Baud 19200: display for exactly HC cycles, then the live value returns
    push_str("19200");
    press(2'b01);
    repeat (3) @(posedge clock);
    #1;
    chk("baud_latency", 32'(baud_mode), 32'h0);
    for (int i = 0; i < HC; i++) begin
      @(posedge clock); #1;
      if (i == 2) see_bauds = 1'b0;
      chk($sformatf("baud_hold%0d", i), {7'h0, baud_mode, digits}, {8'h01, 24'h019200});
    end
    @(posedge clock); #1;
    chk("baud_expire", {7'h0, baud_mode, digits}, {8'h00, 24'h00009F});
    wait_drain(30);

    // Baud 115200 with tx_ready toggling
    toggle_en = 1'b1;
    push_str("115200");
    press(2'b11);
    repeat (6) @(posedge clock);
    #1;
    see_bauds = 1'b0;
    chk("baud_115200", 32'(digits), 32'h115200);
    wait_drain(100);
    toggle_en = 1'b0;
    repeat (HC + 2) @(posedge clock);

    // Button edge and rx '5' in the same cycle: baud string wins, digit still captured
`ifdef UART_ECHO_EN
    exp_q.push_back(8'h0D);
`endif
    send_rx(8'h0D);
    chk("cr_clear", 32'(digits), 32'h0);
    repeat (2) @(posedge clock);
    wait_drain(20);
    push_str("9600");
    press(2'b00);
    repeat (3) @(posedge clock);
    #1;
    rx_data = 8'h35; rx_valid = 1'b1; see_bauds = 1'b0;
    @(posedge clock); #1;
    rx_valid = 1'b0;
    chk("collide_baud", {7'h0, baud_mode, digits}, {8'h01, 24'h009600});
    wait_drain(30);
    repeat (HC + 2) @(posedge clock);
    #1;
    chk("collide_live", 32'(digits), 32'h000005);

    // Reset after the second baud byte aborts the string
    base = n_pop;
    exp_q.push_back(8'h35);
    exp_q.push_back(8'h37);
    press(2'b10);
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (i == 2) see_bauds = 1'b0;
      if (n_pop >= base + 2) break;
    end
    chk("pre_reset_bytes", 32'(n_pop), 32'(base + 2));
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midreset_tx_valid", 32'(tx_valid), 32'h0);
    chk("midreset_digits", 32'(digits), 32'h0);
    chk("midreset_baud_mode", 32'(baud_mode), 32'h0);
    exp_q.delete();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    push_str("57600");
    press(2'b10);
    repeat (4) @(posedge clock);
    #1;
    see_bauds = 1'b0;
    wait_drain(40);
    repeat (HC + 2) @(posedge clock);
    #1;
    chk("post_reset_idle", {7'h0, baud_mode, digits}, 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_display_controller.md
# uart_display_controller

Parametrised successor to the UART register/display controller. Sits between the UART receiver/transmitter and the seven-segment decoders. Received ASCII hex characters shift into a configurable bank of 4-bit digit registers. A `see_bauds` button press shows the selected baud rate in BCD for a programmable hold time and transmits it as an ASCII string.

## Interface

Parameters:
- `NUM_DIGITS`, default 6: number of 4-bit display digits, legal range 1..8.
- `HOLD_CYCLES`, default 50_000_000: clock cycles the baud rate stays displayed; must be ≥ 1.

Ports:
- `clock`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `see_bauds`  in  1  asynchronous push-button, active high.
- `baudrate_sel`  in  2  baud select: 00=9600, 01=19200, 10=57600, 11=115200.
- `tx_ready`  in  1  transmitter can accept a byte.
- `tx_data`  out  8  byte to the transmitter.
- `tx_valid`  out  1  `tx_data` is valid.
- `digits`  out  4*NUM_DIGITS  display digits; digit 0 is `[3:0]` (rightmost).
- `baud_mode`  out  1  high while the baud rate is displayed.

## Operation

- **Live register:** `live[4*NUM_DIGITS-1:0]`.
  - On `rx_valid` with `rx_data` in '0'-'9', 'A'-'F' or 'a'-'f': `live <= {live[4*NUM_DIGITS-5:0], nibble}`; the MSB digit is discarded.
  - On `rx_valid` with 8'h0D (CR): `live <= 0`.
  - Any other byte is ignored.
- **Button path:**
  - `see_bauds` passes through a 2-FF synchroniser, then a rising-edge detect.
  - On the edge: sample `baudrate_sel`, load the BCD constant (009600, 019200, 057600, 115200), load the hold counter with `HOLD_CYCLES-1` and set `baud_mode`.
- **Display:**
  - `digits = baud_mode ? baud_bcd[4*NUM_DIGITS-1:0] : live`.
  - When `NUM_DIGITS` > 6, upper digits show 0.
  - The hold counter decrements each cycle; at 0, `baud_mode` clears.
  - A new edge during `baud_mode` reloads the counter and re-samples `baudrate_sel`.
  - `live` keeps updating while `baud_mode` is high.
- **TX FSM states:** `T_IDLE`, `T_ECHO`, `T_BAUD`, `T_CR`, `T_LF`.
  - `T_IDLE` → `T_BAUD` on a button edge. Priority: this wins over an echo in the same cycle, and that echo is dropped.
  - `T_IDLE` → `T_ECHO` on an accepted `rx_valid` (echo feature only). `tx_data` = `rx_data`.
  - `T_BAUD`: sends the baud digits MSB-first as ASCII (8'h30+d), with leading zeros suppressed, e.g. "9600".
  - `T_BAUD` → `T_CR` (8'h0D) → `T_LF` (8'h0A) → `T_IDLE`.
  - A state advances only on a transfer (`tx_valid & tx_ready`).
  - `T_ECHO` → `T_IDLE` on transfer.
  - Button edges while the FSM is not in `T_IDLE` do not restart transmission; they still update the display.
  - `rx_valid` while the FSM is not in `T_IDLE`: no echo; the digit update still occurs.
- **Reset values:** `live`=0, `digits`=0, `baud_mode`=0, `tx_valid`=0, `tx_data`=8'h00, FSM=`T_IDLE`, synchroniser=0, hold counter=0.
- **Reset mid-string:** aborts the transmission immediately; no partial CR/LF is sent.

## Timing

- `rx_valid` at cycle n → `digits` updated at n+1; echo `tx_valid` high at n+1.
- Synchronised `see_bauds` rise at the pin before edge n → edge detected at n+2; `baud_mode` and `digits` change at n+3; `tx_valid` high at n+3.
- `baud_mode` stays high for exactly `HOLD_CYCLES` cycles after the last edge.
- Handshake: `tx_data` is held stable while `tx_valid & !tx_ready`. `tx_valid` deasserts the cycle after the final transfer. Back-to-back bytes are sent with no bubble when `tx_ready` stays high.

## Configuration

- **`UART_ECHO_EN`**
  - Defined: accepted rx characters (hex digits and CR) are echoed through `T_ECHO`.
  - Undefined: `T_ECHO` is absent. `tx_valid` is asserted only for baud strings. Digit capture is unaffected.

## Test plan

- Reset, then rx "1","a","F" → `digits` low 12 bits = 12'h1AF; other digits 0; with `UART_ECHO_EN`, tx bytes 8'h31, 8'h61, 8'h46.
- `NUM_DIGITS`=6, rx "1234567" → `digits`=24'h234567. Then rx 8'h0D → `digits`=0. Rx "G" → no change, no echo.
- `HOLD_CYCLES`=10, `baudrate_sel`=01, pulse `see_bauds` → `digits`=24'h019200 for 10 cycles, then `live` returns; tx "19200"+CR+LF = 31,39,32,30,30,0D,0A.
- `baudrate_sel`=11, `tx_ready` toggling every other cycle → tx 31,31,35,32,30,30,0D,0A with `tx_data` stable during stalls.
- Button edge and `rx_valid`="5" in the same cycle → baud string only, no echo; `live` digit 0 = 5.
- Assert `reset` after the 2nd baud byte → next cycle `tx_valid`=0, `digits`=0, `baud_mode`=0; the next button press sends the full string from the first character.
